bcd_xs3_conv_seq: RTL and testbench
===================================

Name: bcd_xs3_conv_seq

Overview:
- Parametrised, digit-serial, bidirectional BCD <-> Excess-3 converter for multi-digit words.
- Accepts one packed word of DIGITS nibbles through a valid/ready handshake.
- Converts one digit per clock (least-significant digit first), flags invalid digit codes per digit, and presents the result on a valid/ready output.
- Sits between packed-BCD sources (counters, keypad/display paths) and Excess-3 consumers such as self-complementing arithmetic.

Parameters:
- DIGITS, 4, number of 4-bit digits per word (legal range 1..16).
- CNT_W, $clog2(DIGITS) (minimum 1), width of the digit index counter; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  converter can accept a word
- in_mode  input  1  0 = BCD->XS3, 1 = XS3->BCD; sampled at accept
- in_data  input  4*DIGITS  packed digits; digit 0 = bits [3:0]
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  4*DIGITS  converted digits, same packing as in_data
- out_err_mask  output  DIGITS  bit i set = digit i was an illegal code
- out_err  output  1  OR-reduction of out_err_mask

Behaviour:
- FSM states:
  - IDLE: in_ready=1. On in_valid && in_ready, capture in_data into the work register, latch in_mode, clear cnt, go to CONV.
  - CONV: each cycle convert digit[cnt] and write it back in place; set err bit [cnt] if the digit is illegal; cnt++. After the cycle with cnt==DIGITS-1, go to DONE.
  - DONE: out_valid=1; out_data, out_err_mask and out_err stay stable until out_ready.
    - On out_valid && out_ready: if in_valid, capture the new word and go to CONV (zero-bubble turnaround); otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from state and out_ready, with no in_valid dependency.
- Latency: a word accepted at edge k raises out_valid after edge k+DIGITS.
- Sustained throughput: one word per DIGITS+1 cycles.
- Arithmetic: all 4-bit, modulo 16.
  - BCD->XS3: out = d + 3. Digit is legal iff d <= 9.
  - XS3->BCD: out = d - 3. Digit is legal iff 3 <= d <= 12.
- Illegal digits are still converted modulo 16 and their err bit is set (default build). Legal digits never set err bits.
- Mode is fixed per word. Changing in_mode after accept has no effect on the word in flight.
- Reset values: state=IDLE, cnt=0, work register=0, err mask=0, out_valid=0, out_data=0, out_err_mask=0, out_err=0.
- No word is accepted while rst_n=0. in_ready goes high in the first cycle after deassert.
- Reset asserted in CONV or DONE discards the word immediately (asynchronous). No partial result is ever presented.
- DIGITS=1: CONV lasts one cycle and cnt stays 0.
- in_valid in CONV is ignored, and the word is not consumed, because in_ready=0.

Optional Feature:
- Macro: BCDCONV_ERR_FORCE_EN.
- Defined: any digit flagged illegal is written as 4'hF in out_data. Its err bit is still set.
- Undefined: an illegal digit carries the modulo-16 converted value.
- Legal digits, timing and handshake are identical in both builds.

Decomposition:
- Package bcd_conv_pkg contains:
  - state enum {IDLE, CONV, DONE}
  - constant XS3_OFFSET = 4'd3
  - mode constants MODE_BCD2XS3 = 1'b0, MODE_XS32BCD = 1'b1
  - legality bounds BCD_MAX = 4'd9, XS3_MIN = 4'd3, XS3_MAX = 4'd12
- Sub-module bcd_xs3_digit: purely combinational single-digit converter.
  - Inputs: digit[3:0], mode. Outputs: result[3:0], illegal.
  - Contains the BCDCONV_ERR_FORCE_EN override.
  - One instance, fed by a mux on cnt.
- Top level holds the FSM, counter, work register and handshake.

Test Plan:
- DIGITS=4, in_mode=0, in_data=16'h1905, out_ready=1 -> out_valid exactly 4 cycles after accept; out_data=16'h4C38; out_err_mask=4'b0000.
- in_mode=1, in_data=16'h4C38 -> out_data=16'h1905; out_err=0. Also in_data=16'h3333 -> 16'h0000.
- in_mode=0, in_data=16'h12A9 -> out_err_mask=4'b0010, out_err=1. out_data=16'h45DC with macro undefined, 16'h45FC with BCDCONV_ERR_FORCE_EN defined.
- Hold out_ready=0 for 6 cycles in DONE -> out_valid, out_data and out_err_mask stable; in_ready=0 throughout. Raising out_ready with in_valid=1 accepts the next word in the same cycle.
- Back-to-back words 16'h0000 and 16'h9999 (mode 0) with in_valid and out_ready held high -> results 16'h3333 then 16'hCCCC, spaced 5 cycles apart.
- Pulse rst_n low mid-CONV (after 2 digits) -> out_valid=0 and out_data=0 immediately; in_ready=1 on the first cycle after release; the discarded word never appears on the output.

Source files
------------

// File: rtl/bcd_conv_pkg.sv
// Shared definitions for the digit-serial BCD <-> Excess-3 converter.
//   state_t      : converter FSM states
//   XS3_OFFSET   : Excess-3 bias
//   MODE_*       : conversion direction encoding (in_mode)
//   BCD_MAX, XS3_MIN, XS3_MAX : digit legality bounds
package bcd_conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] XS3_OFFSET   = 4'd3;

  localparam logic       MODE_BCD2XS3 = 1'b0;
  localparam logic       MODE_XS32BCD = 1'b1;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] XS3_MIN      = 4'd3;
  localparam logic [3:0] XS3_MAX      = 4'd12;

endpackage

// File: rtl/bcd_xs3_digit.sv
// Combinational single-digit BCD <-> Excess-3 converter.
//   digit   in  [3:0]  source digit
//   mode    in         0 = BCD->XS3, 1 = XS3->BCD
//   result  out [3:0]  converted digit (modulo 16)
//   illegal out        source digit is not a legal code for the mode
// Build option: BCDCONV_ERR_FORCE_EN replaces the result of an illegal
// digit with 4'hF; otherwise the modulo-16 value passes through.
module bcd_xs3_digit
  import bcd_conv_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       mode,
  output logic [3:0] result,
  output logic       illegal
);

  logic [3:0] raw;

  always_comb begin
    raw     = digit + XS3_OFFSET;
    illegal = 1'b0;
    if (mode == MODE_BCD2XS3) begin
      raw     = digit + XS3_OFFSET;
      illegal = (digit > BCD_MAX);
    end else begin
      raw     = digit - XS3_OFFSET;
      illegal = (digit < XS3_MIN) || (digit > XS3_MAX);
    end
  end

`ifdef BCDCONV_ERR_FORCE_EN
  assign result = illegal ? 4'hF : raw;
`else
  assign result = raw;
`endif

endmodule

// File: rtl/bcd_xs3_conv_seq.sv
// Digit-serial, bidirectional BCD <-> Excess-3 converter for DIGITS-digit
// words. One digit is converted per clock, least-significant first.
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid/in_ready, in_mode, in_data   input word handshake
//   out_valid/out_ready, out_data         result handshake
//   out_err_mask, out_err                 per-digit illegal-code flags
// Build option: BCDCONV_ERR_FORCE_EN (see bcd_xs3_digit).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a word, in_ready=1
// CONV  | converting digit[cnt] in place, one digit per cycle
// DONE  | result held on out_*; may accept the next word on pop
module bcd_xs3_conv_seq
  import bcd_conv_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic [4*DIGITS-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_data,
  output logic [DIGITS-1:0]   out_err_mask,
  output logic                out_err
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [4*DIGITS-1:0] work;
  logic [DIGITS-1:0]   err_mask;
  logic                mode_q;
  logic                accept;
  logic [3:0]          cur_digit;
  logic [3:0]          conv_res;
  logic                conv_illegal;

  assign cur_digit = work[4*cnt +: 4];

  bcd_xs3_digit u_digit (
    .digit   (cur_digit),
    .mode    (mode_q),
    .result  (conv_res),
    .illegal (conv_illegal)
  );

  always_comb begin
    state_nxt = state;
    // rst_n gating keeps in_ready low for the whole reset window.
    in_ready  = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
    accept    = in_valid && in_ready;
    case (state)
      IDLE: if (accept) state_nxt = CONV;
      CONV: if (cnt == LAST) state_nxt = DONE;
      DONE: begin
        if (out_ready) state_nxt = in_valid ? CONV : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      work     <= '0;
      err_mask <= '0;
      mode_q   <= MODE_BCD2XS3;
    end else begin
      state <= state_nxt;
      if (accept) begin
        work     <= in_data;
        mode_q   <= in_mode;
        cnt      <= '0;
        err_mask <= '0;
      end else if (state == CONV) begin
        work[4*cnt +: 4] <= conv_res;
        err_mask[cnt]    <= conv_illegal;
        if (cnt != LAST) cnt <= cnt + 1'b1;
      end
    end
  end

  // Outputs are forced to zero outside DONE so a partially converted
  // word is never visible.
  assign out_valid    = (state == DONE);
  assign out_data     = out_valid ? work : '0;
  assign out_err_mask = out_valid ? err_mask : '0;
  assign out_err      = |out_err_mask;

endmodule

// File: tb/tb_bcd_xs3_conv_seq.sv
module tb_bcd_xs3_conv_seq;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_mode = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [3:0]  out_err_mask;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_xs3_conv_seq #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mode      (in_mode),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_err_mask (out_err_mask),
    .out_err      (out_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word, take it on the next edge, then scramble in_mode and
  // in_data to show the word in flight is unaffected.
  task automatic send_word(input logic mode, input logic [15:0] data);
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    #1;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_mode  = ~mode;
    in_data  = 16'hFFFF;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic run_word(input string tag, input logic mode, input logic [15:0] data,
                          input logic [15:0] exp_data, input logic [3:0] exp_mask);
    int lat;
    send_word(mode, data);
    chk({tag, "_valid_low_after_accept"}, 32'(out_valid), 32'd0);
    wait_out(lat);
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_data"}, 32'(out_data), 32'(exp_data));
    chk({tag, "_mask"}, 32'(out_err_mask), 32'(exp_mask));
    chk({tag, "_err"}, 32'(out_err), 32'(exp_mask != 4'b0000));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_mask", 32'(out_err_mask), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    step();
    step();
    chk("rst_no_accept", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    step();

    // Basic conversions, both directions, legal and illegal codes.
    run_word("b2x_1905", 1'b0, 16'h1905, 16'h4C38, 4'b0000);
    run_word("x2b_4c38", 1'b1, 16'h4C38, 16'h1905, 4'b0000);
    run_word("x2b_3333", 1'b1, 16'h3333, 16'h0000, 4'b0000);
    run_word("x2b_c3c3", 1'b1, 16'hC3C3, 16'h9090, 4'b0000);
`ifdef BCDCONV_ERR_FORCE_EN
    run_word("b2x_12a9", 1'b0, 16'h12A9, 16'h45FC, 4'b0010);
    run_word("x2b_0f3d", 1'b1, 16'h0F3D, 16'hFF0F, 4'b1101);
`else
    run_word("b2x_12a9", 1'b0, 16'h12A9, 16'h45DC, 4'b0010);
    run_word("x2b_0f3d", 1'b1, 16'h0F3D, 16'hDC0A, 4'b1101);
`endif

    // Backpressure: result held, in_ready low, then zero-bubble accept.
    out_ready = 1'b0;
    send_word(1'b0, 16'h1905);
    wait_out(lat);
    chk("hold_latency", 32'(lat), 32'd4);
    in_valid = 1'b1;
    in_mode  = 1'b1;
    in_data  = 16'h4C38;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'h4C38);
      chk("hold_mask", 32'(out_err_mask), 32'd0);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("turnaround_valid_low", 32'(out_valid), 32'd0);
    wait_out(lat);
    chk("turnaround_latency", 32'(lat), 32'd4);
    chk("turnaround_data", 32'(out_data), 32'h1905);
    step();

    // Back-to-back words with in_valid and out_ready held high.
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = 16'h0000;
    step();
    in_data  = 16'h9999;
    wait_out(lat);
    chk("b2b_first_latency", 32'(lat), 32'd4);
    chk("b2b_first_data", 32'(out_data), 32'h3333);
    step();
    in_valid = 1'b0;
    chk("b2b_gap_valid", 32'(out_valid), 32'd0);
    wait_out(lat);
    chk("b2b_second_spacing", 32'(lat + 1), 32'd5);
    chk("b2b_second_data", 32'(out_data), 32'hCCCC);
    step();

    // Reset in the middle of CONV discards the word.
    send_word(1'b0, 16'h9999);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", 32'(in_ready), 32'd1);
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) lat++;
    end
    chk("midrst_no_ghost", 32'(lat), 32'd0);
`ifdef BCDCONV_ERR_FORCE_EN
    run_word("after_rst_0707", 1'b1, 16'h0707, 16'hF4F4, 4'b1010);
`else
    run_word("after_rst_0707", 1'b1, 16'h0707, 16'hD4D4, 4'b1010);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
